// File: rtl/pbvi_pkg.sv
// ---------------------------------------------------------------------------
// pbvi_pkg
// Shared types and helpers for the PBVI argmax action selector.
//   state_t    : controller FSM states (idle, scanning, draining, result held)
//   acc_width  : exact accumulator width for an N_STATE-term dot product of
//                unsigned W-bit belief elements with signed W-bit alpha elements
//   most_neg   : bit pattern of the most negative two's-complement value of a
//                given width, right-aligned in a MAX_ACC_W-bit vector
// ---------------------------------------------------------------------------
package pbvi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int MAX_ACC_W = 128;

  // Each product needs 2*W+1 bits (unsigned W+1 signed x signed W); summing
  // N_STATE of them adds ceil(log2(N_STATE)) bits. $clog2(1)=0 gives the
  // 2*W+1 floor for a single-state belief.
  function automatic int acc_width(input int w, input int n_state);
    return 2 * w + 1 + $clog2(n_state);
  endfunction

  function automatic logic [MAX_ACC_W-1:0] most_neg(input int width);
    logic [MAX_ACC_W-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pbvi_dot.sv
// ---------------------------------------------------------------------------
// pbvi_dot
// Stage 1 of the argmax pipeline: exact belief . alpha dot product followed
// by a register that carries the value, action and vector index.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid        : alpha/action inputs hold a vector this cycle
//   in_index        : index of that vector
//   belief          : N_STATE x W unsigned Q0.W belief (packed, state 0 at LSB)
//   alpha           : N_STATE x W signed alpha elements (packed, state 0 at LSB)
//   in_action       : action associated with the vector
//   out_valid       : registered copy of in_valid
//   out_index       : registered vector index
//   out_action      : registered action
//   out_value       : registered signed dot product, ACC_W bits
// ---------------------------------------------------------------------------
module pbvi_dot
  import pbvi_pkg::*;
#(
  parameter int N_STATE = 2,
  parameter int W       = 16,
  parameter int A_W     = 2,
  parameter int IDX_W   = 4,
  parameter int ACC_W   = acc_width(W, N_STATE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [IDX_W-1:0]        in_index,
  input  logic [N_STATE*W-1:0]    belief,
  input  logic [N_STATE*W-1:0]    alpha,
  input  logic [A_W-1:0]          in_action,
  output logic                    out_valid,
  output logic [IDX_W-1:0]        out_index,
  output logic [A_W-1:0]          out_action,
  output logic signed [ACC_W-1:0] out_value
);

  logic signed [ACC_W-1:0] prod [N_STATE];
  logic signed [ACC_W-1:0] dot;

  // Belief is zero-extended (unsigned Q0.W), alpha is sign-extended, both to
  // the full accumulator width so the product and the sum are exact.
  generate
    for (genvar gi = 0; gi < N_STATE; gi++) begin : g_mul
      logic signed [ACC_W-1:0] b_wide;
      logic signed [ACC_W-1:0] a_wide;
      assign b_wide   = {{(ACC_W-W){1'b0}}, belief[gi*W +: W]};
      assign a_wide   = {{(ACC_W-W){alpha[gi*W+W-1]}}, alpha[gi*W +: W]};
      assign prod[gi] = b_wide * a_wide;
    end
  endgenerate

  always_comb begin
    dot = '0;
    for (int s = 0; s < N_STATE; s++) begin
      dot = dot + prod[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_action <= '0;
      out_value  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_index  <= in_index;
        out_action <= in_action;
        out_value  <= dot;
      end
    end
  end

endmodule

// File: rtl/pbvi_argmax_decider.sv
// ---------------------------------------------------------------------------
// pbvi_argmax_decider
// Scans alpha vectors 0..n_eff-1 from an external store, computes each one's
// dot product with the latched belief and returns the argmax (lowest index
// on ties) with its value and action.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start_valid/start_ready : request handshake (ready only in IDLE)
//   belief                  : N_STATE x W unsigned belief, latched on accept
//   n_active                : vectors to scan, latched on accept (clamped)
//   rd_en, rd_idx           : store read request, one per SCAN cycle
//   rd_alpha, rd_action     : store data, valid the cycle after rd_en
//   out_valid/out_ready     : result handshake, result held until accepted
//   out_action, out_index   : argmax vector's action and index
//   out_value               : argmax dot product (signed, ACC_W bits)
//   out_none                : no vector scanned (n_eff == 0)
// ---------------------------------------------------------------------------
module pbvi_argmax_decider
  import pbvi_pkg::*;
#(
  parameter  int N_ALPHA = 16,
  parameter  int N_STATE = 2,
  parameter  int W       = 16,
  parameter  int A_W     = 2,
  localparam int IDX_W   = $clog2(N_ALPHA),
  localparam int CNT_W   = $clog2(N_ALPHA + 1),
  localparam int ACC_W   = acc_width(W, N_STATE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [N_STATE*W-1:0]    belief,
  input  logic [CNT_W-1:0]        n_active,
  output logic                    rd_en,
  output logic [IDX_W-1:0]        rd_idx,
  input  logic [N_STATE*W-1:0]    rd_alpha,
  input  logic [A_W-1:0]          rd_action,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [A_W-1:0]          out_action,
  output logic [IDX_W-1:0]        out_index,
  output logic signed [ACC_W-1:0] out_value,
  output logic                    out_none
);

  localparam logic [ACC_W-1:0] MOST_NEG = ACC_W'(most_neg(ACC_W));

  state_t                  state;
  logic [N_STATE*W-1:0]    belief_reg;
  logic [CNT_W-1:0]        n_eff_reg;
  logic [CNT_W-1:0]        n_eff_in;
  logic                    zero_wait;

  // Read issued last cycle: its data is on rd_alpha/rd_action now.
  logic                    pend_valid;
  logic [IDX_W-1:0]        pend_index;

  // Stage-1 outputs
  logic                    s1_valid;
  logic [IDX_W-1:0]        s1_index;
  logic [A_W-1:0]          s1_action;
  logic signed [ACC_W-1:0] s1_value;

  // Stage-2 running best
  logic signed [ACC_W-1:0] best_value;
  logic [IDX_W-1:0]        best_index;
  logic [A_W-1:0]          best_action;

  logic                    take;
  logic                    s1_last;
  logic                    scan_last;

  assign n_eff_in = (n_active > CNT_W'(N_ALPHA)) ? CNT_W'(N_ALPHA) : n_active;

  pbvi_dot #(
    .N_STATE (N_STATE),
    .W       (W),
    .A_W     (A_W),
    .IDX_W   (IDX_W),
    .ACC_W   (ACC_W)
  ) u_dot (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (pend_valid),
    .in_index   (pend_index),
    .belief     (belief_reg),
    .alpha      (rd_alpha),
    .in_action  (rd_action),
    .out_valid  (s1_valid),
    .out_index  (s1_index),
    .out_action (s1_action),
    .out_value  (s1_value)
  );

  // Index 0 is always the first vector of a scan, so it seeds best without a
  // compare; later vectors must be strictly greater, keeping the lowest index
  // on ties.
  assign take      = s1_valid && ((s1_index == '0) || (s1_value > best_value));
  assign s1_last   = s1_valid && (CNT_W'(s1_index) == (n_eff_reg - CNT_W'(1)));
  assign scan_last = (CNT_W'(rd_idx) == (n_eff_reg - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      start_ready <= 1'b1;
      belief_reg  <= '0;
      n_eff_reg   <= '0;
      zero_wait   <= 1'b0;
      rd_en       <= 1'b0;
      rd_idx      <= '0;
      pend_valid  <= 1'b0;
      pend_index  <= '0;
      best_value  <= '0;
      best_index  <= '0;
      best_action <= '0;
      out_valid   <= 1'b0;
      out_action  <= '0;
      out_index   <= '0;
      out_value   <= '0;
      out_none    <= 1'b0;
    end else begin
      pend_valid <= rd_en;
      pend_index <= rd_idx;

      if (take) begin
        best_value  <= s1_value;
        best_index  <= s1_index;
        best_action <= s1_action;
      end

      case (state)
        ST_IDLE: begin
          if (start_valid && start_ready) begin
            belief_reg  <= belief;
            n_eff_reg   <= n_eff_in;
            start_ready <= 1'b0;
            if (n_eff_in == '0) begin
              // Nothing to read: spend the same two-cycle pipeline delay
              // in DRAIN so an empty request still answers at E2.
              zero_wait <= 1'b1;
              state     <= ST_DRAIN;
            end else begin
              rd_en  <= 1'b1;
              rd_idx <= '0;
              state  <= ST_SCAN;
            end
          end
        end

        ST_SCAN: begin
          if (scan_last) begin
            rd_en  <= 1'b0;
            rd_idx <= '0;
            state  <= ST_DRAIN;
          end else begin
            rd_idx <= rd_idx + 1'b1;
          end
        end

        ST_DRAIN: begin
          if (n_eff_reg == '0) begin
            if (zero_wait) begin
              zero_wait <= 1'b0;
            end else begin
              out_valid  <= 1'b1;
              out_none   <= 1'b1;
              out_index  <= '0;
              out_action <= '0;
              out_value  <= MOST_NEG;
              state      <= ST_DONE;
            end
          end else if (s1_last) begin
            // Final compare happens on this edge; publish its outcome
            // directly rather than waiting for best to settle.
            out_valid  <= 1'b1;
            out_none   <= 1'b0;
            out_value  <= take ? s1_value  : best_value;
            out_index  <= take ? s1_index  : best_index;
            out_action <= take ? s1_action : best_action;
            state      <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbvi_argmax_decider.sv
// ---------------------------------------------------------------------------
// tb_pbvi_argmax_decider
// Self-checking bench: directed vector table, handshake/reset sequences and
// randomized requests checked against an arithmetic argmax reference.
// ---------------------------------------------------------------------------
module tb_pbvi_argmax_decider;

  localparam int N_ALPHA = 16;
  localparam int N_STATE = 2;
  localparam int W       = 16;
  localparam int A_W     = 2;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 5;
  localparam int ACC_W   = 34;
  localparam int PERIOD  = 10;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start_valid;
  logic                    start_ready;
  logic [N_STATE*W-1:0]    belief;
  logic [CNT_W-1:0]        n_active;
  logic                    rd_en;
  logic [IDX_W-1:0]        rd_idx;
  logic [N_STATE*W-1:0]    rd_alpha;
  logic [A_W-1:0]          rd_action;
  logic                    out_valid;
  logic                    out_ready;
  logic [A_W-1:0]          out_action;
  logic [IDX_W-1:0]        out_index;
  logic signed [ACC_W-1:0] out_value;
  logic                    out_none;

  always #(PERIOD/2) clk = ~clk;

  pbvi_argmax_decider #(
    .N_ALPHA (N_ALPHA),
    .N_STATE (N_STATE),
    .W       (W),
    .A_W     (A_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .belief      (belief),
    .n_active    (n_active),
    .rd_en       (rd_en),
    .rd_idx      (rd_idx),
    .rd_alpha    (rd_alpha),
    .rd_action   (rd_action),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_action  (out_action),
    .out_index   (out_index),
    .out_value   (out_value),
    .out_none    (out_none)
  );

  // Alpha/action store with a one-cycle registered read port.
  logic signed [15:0] alpha0 [N_ALPHA];
  logic signed [15:0] alpha1 [N_ALPHA];
  logic [A_W-1:0]     act_mem [N_ALPHA];
  int                 idx_log[$];
  longint             acc_time[$];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_alpha  <= {alpha1[rd_idx], alpha0[rd_idx]};
      rd_action <= act_mem[rd_idx];
      idx_log.push_back(int'(rd_idx));
    end
  end

  always @(posedge clk) begin
    if (rst_n && start_valid && start_ready) acc_time.push_back(longint'($time));
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < N_ALPHA; i++) begin
      case (mode)
        0: begin alpha0[i] = 16'(i); alpha1[i] = 16'(i); act_mem[i] = 2'(i); end
        1: begin alpha0[i] = 16'sd5; alpha1[i] = 16'sd5; act_mem[i] = 2'(i); end
        2: begin alpha0[i] = -16'(100 + i); alpha1[i] = -16'sd50; act_mem[i] = 2'(i); end
        default: begin
          alpha0[i]  = 16'($urandom);
          alpha1[i]  = ($urandom_range(0, 3) == 0) ? 16'sd7 : 16'($urandom);
          act_mem[i] = 2'($urandom);
        end
      endcase
    end
    if (mode == 0) begin alpha0[9] = 16'h7FFF; alpha1[9] = 16'h7FFF; act_mem[9] = 2'd2; end
    if (mode == 2) begin alpha0[3] = -16'sd1; alpha1[3] = -16'sd1; end
  endtask

  // Reference: plain arithmetic argmax over the first min(na,16) vectors.
  task automatic model(input logic [15:0] b0, input logic [15:0] b1, input int na,
                       output int ei, output int ea, output longint ev, output bit en);
    int n;
    longint d;
    n  = (na > N_ALPHA) ? N_ALPHA : na;
    en = (n == 0);
    ei = 0;
    ea = 0;
    ev = -(longint'(1) << (ACC_W - 1));
    for (int i = 0; i < n; i++) begin
      d = longint'(b0) * longint'(alpha0[i]) + longint'(b1) * longint'(alpha1[i]);
      if (i == 0 || d > ev) begin
        ev = d;
        ei = i;
        ea = int'(act_mem[i]);
      end
    end
  endtask

  task automatic do_req(input string name, input logic [15:0] b0, input logic [15:0] b1,
                        input int na, input int hold, input bit poke,
                        input int e_idx, input int e_act, input longint e_val,
                        input bit e_none, input int e_lat);
    int lat;
    bit got;
    bit seq_ok;
    int n_eff;
    n_eff = (na > N_ALPHA) ? N_ALPHA : na;
    @(negedge clk);
    chk({name, ".start_ready"}, start_ready, 1);
    idx_log.delete();
    start_valid = 1'b1;
    belief      = {b1, b0};
    n_active    = CNT_W'(na);
    out_ready   = (hold == 0);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    belief      = $urandom;
    n_active    = CNT_W'($urandom);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) got = 1'b1;
      else if (poke) start_valid = ~start_valid;
    end
    start_valid = 1'b0;
    chk({name, ".got_valid"}, got, 1);
    chk({name, ".latency"}, lat, e_lat);
    chk({name, ".index"}, out_index, e_idx);
    chk({name, ".action"}, out_action, e_act);
    chk({name, ".value"}, out_value, e_val);
    chk({name, ".none"}, out_none, e_none);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({name, ".hold_valid"}, out_valid, 1);
      chk({name, ".hold_value"}, out_value, e_val);
      chk({name, ".hold_start_ready"}, start_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, ".valid_drop"}, out_valid, 0);
    chk({name, ".ready_back"}, start_ready, 1);
    out_ready = 1'b0;
    chk({name, ".read_count"}, idx_log.size(), n_eff);
    seq_ok = 1'b1;
    foreach (idx_log[i]) if (idx_log[i] != i) seq_ok = 1'b0;
    chk({name, ".read_order"}, seq_ok, 1);
    $display("[TB] %s: index=%0d action=%0d value=%0d none=%0d latency=%0d",
             name, out_index, out_action, out_value, out_none, lat);
  endtask

  typedef struct {
    string       name;
    int          mode;
    logic [15:0] b0;
    logic [15:0] b1;
    int          na;
    int          e_idx;
    int          e_act;
    longint      e_val;
    bit          e_none;
    int          e_lat;
  } vec_t;

  localparam longint MOST_NEG = -(longint'(1) << (ACC_W - 1));

  vec_t vecs[7];

  initial begin
    int     ei, ea, cyc, nlog, na;
    longint ev;
    bit     en;
    logic [15:0] rb0, rb1;

    vecs[0] = '{"max9",    0, 16'h8000, 16'h8000, 16, 9, 2, 64'h7FFF0000, 1'b0, 18};
    vecs[1] = '{"ties",    1, 16'h8000, 16'h8000, 16, 0, 0, 64'h50000,    1'b0, 18};
    vecs[2] = '{"signed",  2, 16'hFFFF, 16'h0000, 16, 3, 3, -64'hFFFF,    1'b0, 18};
    vecs[3] = '{"n0",      0, 16'h8000, 16'h8000, 0,  0, 0, MOST_NEG,     1'b1, 2};
    vecs[4] = '{"n20",     0, 16'h8000, 16'h8000, 20, 9, 2, 64'h7FFF0000, 1'b0, 18};
    vecs[5] = '{"n1",      0, 16'h8000, 16'h8000, 1,  0, 0, 0,            1'b0, 3};
    vecs[6] = '{"n5",      0, 16'h8000, 16'h8000, 5,  4, 0, 64'h40000,    1'b0, 7};

    start_valid = 1'b0;
    belief      = '0;
    n_active    = '0;
    out_ready   = 1'b0;
    fill(0);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.start_ready", start_ready, 1);
    chk("reset.rd_en", rd_en, 0);
    chk("reset.rd_idx", rd_idx, 0);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.out_value", out_value, 0);
    chk("reset.out_none", out_none, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].mode);
      do_req(vecs[v].name, vecs[v].b0, vecs[v].b1, vecs[v].na, 0, 1'b0,
             vecs[v].e_idx, vecs[v].e_act, vecs[v].e_val, vecs[v].e_none, vecs[v].e_lat);
    end

    // Result held with out_ready low for 5 cycles.
    fill(0);
    do_req("hold5", 16'h8000, 16'h8000, 16, 5, 1'b0, 9, 2, 64'h7FFF0000, 1'b0, 18);

    // start_valid toggling while busy must not disturb the scan.
    fill(2);
    do_req("poke", 16'hFFFF, 16'h0000, 16, 0, 1'b1, 3, 3, -64'hFFFF, 1'b0, 18);

    // Back-to-back: second request accepted n_eff+4 cycles after the first.
    fill(0);
    do_req("b2b_a", 16'h8000, 16'h8000, 5, 0, 1'b0, 4, 0, 64'h40000, 1'b0, 7);
    do_req("b2b_b", 16'h0000, 16'h8000, 3, 0, 1'b0, 2, 2, 64'h10000, 1'b0, 5);
    chk("b2b.throughput", acc_time[$] - acc_time[$-1], (5 + 4) * PERIOD);

    // Randomized requests against the reference model.
    for (int r = 0; r < 12; r++) begin
      fill(3);
      rb0 = 16'($urandom);
      rb1 = 16'($urandom);
      na  = $urandom_range(0, 18);
      model(rb0, rb1, na, ei, ea, ev, en);
      do_req($sformatf("rand%0d", r), rb0, rb1, na, $urandom_range(0, 2), 1'b0,
             ei, ea, ev, en, ((na > N_ALPHA) ? N_ALPHA : na) + 2);
    end

    // Reset asserted while rd_idx=7 is on the bus.
    fill(0);
    @(negedge clk);
    start_valid = 1'b1;
    belief      = {16'h8000, 16'h8000};
    n_active    = CNT_W'(16);
    out_ready   = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    cyc = 0;
    while (!(rd_en && rd_idx == 4'd7) && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rst.reach_idx7", rd_idx, 7);
    rst_n = 1'b0;
    nlog  = idx_log.size();
    @(posedge clk);
    #1;
    chk("rst.rd_en", rd_en, 0);
    chk("rst.rd_idx", rd_idx, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_index", out_index, 0);
    chk("rst.out_action", out_action, 0);
    chk("rst.out_value", out_value, 0);
    chk("rst.out_none", out_none, 0);
    chk("rst.start_ready", start_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.no_reads", idx_log.size(), nlog);
    chk("rst.no_result", out_valid, 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req("post_rst", 16'h8000, 16'h8000, 16, 0, 1'b0, 9, 2, 64'h7FFF0000, 1'b0, 18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(200000 * PERIOD);
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/pbvi_argmax_decider.md
# pbvi_argmax_decider

Parametrised PBVI action selector: given the current belief over `N_STATE` states, it scans up to `N_ALPHA` alpha vectors held in an external alpha/action store. For each vector it computes the exact dot product with the belief and returns the argmax vector's index, value and associated action. It sits between the belief-update stage and the observation stage of the POMDP controller, with ready/valid handshakes on both sides and a 1-cycle-latency read port into the store.

## Interface
- `N_ALPHA`, 16: alpha vectors in store (≥2).
- `N_STATE`, 2: belief/alpha dimension (≥1).
- `W`, 16: belief and alpha element width.
- `A_W`, 2: action width.
- Derived `IDX_W = $clog2(N_ALPHA)`, `CNT_W = $clog2(N_ALPHA+1)`, `ACC_W = 2*W + 1 + $clog2(N_STATE)` (min `2*W+1`).

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_valid` in 1, `start_ready` out 1: request handshake.
- `belief` in `N_STATE`×W: unsigned Q0.W per state, sampled on accept.
- `n_active` in CNT_W: number of vectors to scan (indices `0..n_active-1`), sampled on accept.
- `rd_en` out 1, `rd_idx` out IDX_W: store read request.
- `rd_alpha` in `N_STATE`×W: signed alpha elements, valid in the cycle after `rd_en`.
- `rd_action` in A_W: action for that vector, same timing as `rd_alpha`.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_action` out A_W, `out_index` out IDX_W, `out_value` out ACC_W signed.
- `out_none` out 1: set when no vector was scanned.

## Operation
- FSM states: IDLE → SCAN → DRAIN → DONE → IDLE.
- IDLE:
  - `start_ready=1`.
  - On `start_valid&&start_ready`, latch belief and `n_eff = min(n_active, N_ALPHA)`.
  - If `n_eff==0`, go to DRAIN with no reads; otherwise go to SCAN.
- SCAN: `rd_en=1` with `rd_idx=k` for k = 0..n_eff-1, one per cycle. After the last read, go to DRAIN.
- Datapath, 2 stages:
  - Stage 1, cycle after read: `dot = Σ zext(belief[s]) * alpha[s]`, signed, ACC_W bits, no truncation or saturation. `dot`, `rd_action` and the index are registered.
  - Stage 2: compare against `best`.
- Compare rules:
  - The first vector loads `best` unconditionally.
  - A later vector replaces `best` only if strictly greater. Ties therefore keep the lowest index.
- DRAIN: waits until stage 2 has consumed the last vector, then goes to DONE.
- DONE:
  - `out_valid=1`; outputs are stable until `out_ready`.
  - On the handshake, go to IDLE.
  - `start_ready=0` in every state except IDLE.
- `out_none=1` only when `n_eff==0`. In that case `out_index=0`, `out_action=0` and `out_value` is the most negative ACC_W value.
- `start_valid` while busy is ignored. No request is queued.

## Timing
- Reset values:
  - State is IDLE.
  - `start_ready=1` after reset.
  - `rd_en=0`, `rd_idx=0`, `out_valid=0`, `out_action=0`, `out_index=0`, `out_value=0`, `out_none=0`.
  - All pipeline registers are cleared.
- Let E0 be the accept edge.
  - `rd_idx=k` is driven in the cycle after edge E(k).
  - `best` is final at edge E(n_eff+2).
  - `out_valid` rises at E(n_eff+2), i.e. latency is n_eff+2 cycles.
  - For `n_eff==0`, `out_valid` rises at E2.
- `out_ready` may already be high when `out_valid` rises. Completion then takes 1 cycle, and `start_ready` rises the next cycle.
- Back-to-back throughput is `n_eff+4` cycles per request.
- Reset asserted mid-scan aborts immediately: all outputs go to reset values, with no partial result and no further reads.
- Inputs `belief` and `n_active` may change freely after accept.

## Structure
- `pbvi_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_SCAN`, `ST_DRAIN`, `ST_DONE`).
  - Width helper function for ACC_W.
  - Most-negative constant helper.
- Sub-module `pbvi_dot`: parametrised N_STATE×W combinational multiply-add plus stage-1 register (value, action, index, valid).
- The top holds the FSM, read counter, stage-2 compare and output registers.

## Test plan
- N_ALPHA=16, N_STATE=2:
  - belief={0x8000,0x8000}; alpha[i]={i,i}, except alpha[9]={0x7FFF,0x7FFF}; action[9]=2; n_active=16.
  - Expect out_index=9, out_action=2, out_value=0x7FFF*0x10000, out_valid at E18.
- Ties: all alpha={5,5}, n_active=16 → out_index=0 (lowest index wins).
- Signed values: all alpha negative, alpha[3]={-1,-1}, belief={0xFFFF,0} → out_index=3, out_value=-0xFFFF.
- n_active boundaries:
  - n_active=0 → no rd_en, out_none=1, out_valid at E2.
  - n_active=20 → exactly 16 reads, max over all 16.
  - n_active=1 → out_index=0, latency 3.
- Handshakes:
  - Hold out_ready=0 for 5 cycles; outputs stay stable and start_ready stays 0.
  - start_valid pulses during SCAN are ignored.
  - A back-to-back second request returns its own correct result.
- Reset: assert rst_n=0 at rd_idx=7 → next cycle all outputs are at reset values. A new request afterwards completes correctly.
